// File: rtl/feeder_pkg.sv
// Shared definitions for the activation skew feeder: the batch-framing
// state encoding and the width helper for the drain down-counter.
package feeder_pkg;

  // IDLE waits for the first vector of a batch, STREAM accepts one vector
  // per cycle, DRAIN flushes the skew lines after the final vector.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

  // The drain counter must hold SIZE-1. One extra bit keeps SIZE=1 legal,
  // which would otherwise give a zero-width counter.
  function automatic int DRAIN_CNT_W(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay line carrying one activation lane plus its valid flag.
// A vector entering at stage 0 appears on the output DEPTH cycles later.
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  // Shift every stage one step toward the output; reset empties the line so
  // a discarded batch never leaks into the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      data_q[0]  <= data_i;
      valid_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/act_skew_feeder.sv
// Upstream feeder for the systolic matrix-multiply array. Accepts one
// activation vector per cycle and presents it diagonally skewed: row r is
// delayed r cycles behind row 0, with zeros in every empty slot. Batches are
// framed by in_last; after the last vector the skew lines are drained and
// done pulses as the final element reaches the bottom row.
module act_skew_feeder
  import feeder_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [SIZE],
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] data_out [SIZE],
  output logic [SIZE-1:0]       row_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int             CntW    = DRAIN_CNT_W(SIZE);
  localparam logic [CntW-1:0] CntLoad = CntW'(SIZE - 1);

  feeder_state_t   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            handshake;

  // Readiness depends on the state register alone, so there is no path from
  // in_valid back to in_ready.
  assign in_ready  = (state_q != DRAIN);
  assign handshake = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DRAIN) && (cnt_q == '0);

  // State and drain-counter registers; reset abandons any batch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Batch framing: the last accepted vector loads SIZE-1 so DRAIN lasts
  // exactly SIZE cycles, ending on the cycle the bottom row shows its data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, STREAM: begin
        if (handshake) begin
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CntLoad;
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One delay line per row, depth r+1; a cycle without a handshake pushes a
  // zero bubble so unused slots never carry stale data.
  for (genvar r = 0; r < SIZE; r++) begin : g_row
    logic [DATA_WIDTH-1:0] lane_in;

    assign lane_in = handshake ? in_data[r] : '0;

    skew_line #(
      .DEPTH      (r + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_line (
      .clk     (clk),
      .rst     (rst),
      .data_i  (lane_in),
      .valid_i (handshake),
      .data_o  (data_out[r]),
      .valid_o (row_valid[r])
    );
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder: a cycle table for SIZE=3 covering
// back-to-back streaming, bubbles, in_valid during drain, plus hand-written
// sequences for mid-batch reset and the SIZE=1 corner.
module tb_act_skew_feeder;

  logic clk;
  logic rst;

  // SIZE=3 instance
  logic       inValid;
  logic       inReady;
  logic [7:0] inData  [3];
  logic       inLast;
  logic [7:0] dataOut [3];
  logic [2:0] rowValid;
  logic       busy;
  logic       done;

  // SIZE=1 instance
  logic       inValid1;
  logic       inReady1;
  logic [7:0] inData1  [1];
  logic       inLast1;
  logic [7:0] dataOut1 [1];
  logic [0:0] rowValid1;
  logic       busy1;
  logic       done1;

  int checks;
  int errors;

  typedef struct {
    logic       v;
    logic       last;
    logic [7:0] d0, d1, d2;
    logic       eReady, eBusy, eDone;
    logic [2:0] eRv;
    logic [7:0] e0, e1, e2;
  } vec_t;

  vec_t vecs[$];

  act_skew_feeder #(.SIZE(3), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .in_last   (inLast),
    .data_out  (dataOut),
    .row_valid (rowValid),
    .busy      (busy),
    .done      (done)
  );

  act_skew_feeder #(.SIZE(1), .DATA_WIDTH(8)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid1),
    .in_ready  (inReady1),
    .in_data   (inData1),
    .in_last   (inLast1),
    .data_out  (dataOut1),
    .row_valid (rowValid1),
    .busy      (busy1),
    .done      (done1)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic v, input logic last,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input logic eReady, input logic eBusy, input logic eDone,
                        input logic [2:0] eRv,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    vec_t t;
    t.v = v; t.last = last; t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.eReady = eReady; t.eBusy = eBusy; t.eDone = eDone; t.eRv = eRv;
    t.e0 = e0; t.e1 = e1; t.e2 = e2;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input vec_t t);
    inValid   = t.v;
    inLast    = t.last;
    inData[0] = t.d0;
    inData[1] = t.d1;
    inData[2] = t.d2;
  endtask

  task automatic checkOutput(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkVal({tag, " in_ready"},  32'(inReady),    32'(t.eReady));
    checkVal({tag, " busy"},      32'(busy),       32'(t.eBusy));
    checkVal({tag, " done"},      32'(done),       32'(t.eDone));
    checkVal({tag, " row_valid"}, 32'(rowValid),   32'(t.eRv));
    checkVal({tag, " data0"},     32'(dataOut[0]), 32'(t.e0));
    checkVal({tag, " data1"},     32'(dataOut[1]), 32'(t.e1));
    checkVal({tag, " data2"},     32'(dataOut[2]), 32'(t.e2));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    inValid  = 1'b0;
    inLast   = 1'b0;
    inData[0] = 8'd0; inData[1] = 8'd0; inData[2] = 8'd0;
    inValid1 = 1'b0;
    inLast1  = 1'b0;
    inData1[0] = 8'd0;

    // Idle cycles after reset: nothing may become valid
    //     v  last d0 d1 d2  rdy busy done rv    e0 e1 e2
    addVec(0, 0,   0, 0, 0,  1,  0,   0,   3'b000, 0, 0, 0);
    addVec(0, 0,   0, 0, 0,  1,  0,   0,   3'b000, 0, 0, 0);
    // Back-to-back {1,2,3},{4,5,6},{7,8,9}+last
    addVec(1, 0,   1, 2, 3,  1,  0,   0,   3'b000, 0, 0, 0);
    addVec(1, 0,   4, 5, 6,  1,  1,   0,   3'b001, 1, 0, 0);
    addVec(1, 1,   7, 8, 9,  1,  1,   0,   3'b011, 4, 2, 0);
    addVec(0, 0,   0, 0, 0,  0,  1,   0,   3'b111, 7, 5, 3);
    addVec(0, 0,   0, 0, 0,  0,  1,   0,   3'b110, 0, 8, 6);
    addVec(0, 0,   0, 0, 0,  0,  1,   1,   3'b100, 0, 0, 9);
    addVec(0, 0,   0, 0, 0,  1,  0,   0,   3'b000, 0, 0, 0);
    // Bubble: {1,1,1}, idle cycle with stray in_last, {2,2,2}+last
    addVec(1, 0,   1, 1, 1,  1,  0,   0,   3'b000, 0, 0, 0);
    addVec(0, 1,   7, 7, 7,  1,  1,   0,   3'b001, 1, 0, 0);
    addVec(1, 1,   2, 2, 2,  1,  1,   0,   3'b010, 0, 1, 0);
    addVec(0, 0,   0, 0, 0,  0,  1,   0,   3'b101, 2, 0, 1);
    addVec(0, 0,   0, 0, 0,  0,  1,   0,   3'b010, 0, 2, 0);
    addVec(0, 0,   0, 0, 0,  0,  1,   1,   3'b100, 0, 0, 2);
    addVec(0, 0,   0, 0, 0,  1,  0,   0,   3'b000, 0, 0, 0);
    // Single-vector batch, then {9,9,9} held through DRAIN until accepted
    addVec(1, 1,   1, 2, 3,  1,  0,   0,   3'b000, 0, 0, 0);
    addVec(1, 1,   9, 9, 9,  0,  1,   0,   3'b001, 1, 0, 0);
    addVec(1, 1,   9, 9, 9,  0,  1,   0,   3'b010, 0, 2, 0);
    addVec(1, 1,   9, 9, 9,  0,  1,   1,   3'b100, 0, 0, 3);
    addVec(1, 1,   9, 9, 9,  1,  0,   0,   3'b000, 0, 0, 0);
    addVec(0, 0,   0, 0, 0,  0,  1,   0,   3'b001, 9, 0, 0);
    addVec(0, 0,   0, 0, 0,  0,  1,   0,   3'b010, 0, 9, 0);
    addVec(0, 0,   0, 0, 0,  0,  1,   1,   3'b100, 0, 0, 9);
    addVec(0, 0,   0, 0, 0,  1,  0,   0,   3'b000, 0, 0, 0);

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst in_ready",  32'(inReady),  32'd1);
    checkVal("rst busy",      32'(busy),     32'd0);
    checkVal("rst done",      32'(done),     32'd0);
    checkVal("rst row_valid", 32'(rowValid), 32'd0);
    checkVal("rst data2",     32'(dataOut[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // Mid-batch reset: two vectors accepted, then reset during cycle 1
    @(negedge clk);
    inValid = 1'b1; inLast = 1'b0;
    inData[0] = 8'h11; inData[1] = 8'h12; inData[2] = 8'h13;
    @(negedge clk);
    inData[0] = 8'h21; inData[1] = 8'h22; inData[2] = 8'h23;
    #1;
    checkVal("pre-rst row_valid", 32'(rowValid), 32'b001);
    checkVal("pre-rst data0",     32'(dataOut[0]), 32'h11);
    #1;
    rst = 1'b1;
    inValid = 1'b0;
    #1;
    checkVal("midrst row_valid", 32'(rowValid), 32'd0);
    checkVal("midrst data0",     32'(dataOut[0]), 32'd0);
    checkVal("midrst busy",      32'(busy),     32'd0);
    checkVal("midrst in_ready",  32'(inReady),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checkVal($sformatf("postrst%0d row_valid", c), 32'(rowValid), 32'd0);
      checkVal($sformatf("postrst%0d done", c),      32'(done),     32'd0);
      checkVal($sformatf("postrst%0d busy", c),      32'(busy),     32'd0);
    end

    // SIZE=1: single vector {5}+last
    @(negedge clk);
    inValid1 = 1'b1; inLast1 = 1'b1; inData1[0] = 8'd5;
    #1;
    checkVal("s1 c0 in_ready", 32'(inReady1), 32'd1);
    checkVal("s1 c0 busy",     32'(busy1),    32'd0);
    @(negedge clk);
    inValid1 = 1'b0; inLast1 = 1'b0; inData1[0] = 8'd0;
    #1;
    checkVal("s1 c1 data0",     32'(dataOut1[0]), 32'd5);
    checkVal("s1 c1 row_valid", 32'(rowValid1),   32'd1);
    checkVal("s1 c1 done",      32'(done1),       32'd1);
    checkVal("s1 c1 in_ready",  32'(inReady1),    32'd0);
    checkVal("s1 c1 busy",      32'(busy1),       32'd1);
    @(negedge clk);
    #1;
    checkVal("s1 c2 in_ready",  32'(inReady1),  32'd1);
    checkVal("s1 c2 busy",      32'(busy1),     32'd0);
    checkVal("s1 c2 done",      32'(done1),     32'd0);
    checkVal("s1 c2 row_valid", 32'(rowValid1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_skew_feeder.md
# act_skew_feeder

Upstream feeder for the systolic matrix-multiply unit. Accepts one activation vector per cycle over a valid/ready handshake and drives the array's per-row `data_in` lanes with the diagonal skew the array needs: row r is delayed by r cycles relative to row 0, and zeros fill every slot that carries no data. It frames batches with `in_last`, drains the skew pipeline after the final vector, and pulses `done` when the final element has entered the array.

## Interface
- `SIZE`, default 2: array dimension; the number of lanes.
- `DATA_WIDTH`, default 8: activation width.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_valid`  in  1: an input vector is present.
- `in_ready`  out  1: the feeder can accept a vector.
- `in_data`  in  `DATA_WIDTH` x `SIZE` (unpacked): activation vector; element r goes to row r.
- `in_last`  in  1: the vector is the last of its batch; sampled only on handshake.
- `data_out`  out  `DATA_WIDTH` x `SIZE` (unpacked): skewed lanes, connected to the array's `data_in`.
- `row_valid`  out  `SIZE`: bit r is high when `data_out[r]` carries a real element.
- `busy`  out  1: a batch is in progress (state is not IDLE).
- `done`  out  1: one-cycle pulse when the last element of the batch is on `data_out[SIZE-1]`.

## Operation
- A handshake occurs in a cycle where `in_valid && in_ready` are both high.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: `in_ready`=1. A handshake goes to STREAM, or to DRAIN if `in_last`=1.
  - STREAM: `in_ready`=1. A handshake with `in_last`=1 goes to DRAIN. A cycle with no handshake inserts a bubble: zero data, valid 0.
  - DRAIN: `in_ready`=0. A down-counter of width `$clog2(SIZE)+1` is loaded with SIZE-1 on the last handshake and decrements each DRAIN cycle. When the count is 0, `done`=1 and the next state is IDLE.
- Per-row delay line: row r has depth r+1 registers holding data and valid. Each cycle it shifts in `in_data[r]` and 1 on a handshake, otherwise 0 and 0.
- Data passes through unmodified. There is no arithmetic and no width change.
- `in_valid` while `in_ready`=0 is ignored. The source must hold its data, and nothing is captured.
- `in_last` with no handshake has no effect.
- SIZE=1: DRAIN lasts exactly one cycle, with `done` high in that cycle.
- Reset mid-batch: all delay lines clear, the partial batch is discarded, and the next state is IDLE. No `done` is produced.
- Reset values:
  - `data_out`=0, `row_valid`=0, `done`=0, `busy`=0.
  - `in_ready`=1, taken combinationally from IDLE; it is 1 from the first cycle after reset deasserts.

## Timing
- Handshake in cycle T: element r is visible on `data_out[r]` during cycle T+1+r, with `row_valid[r]`=1.
- Last handshake in cycle T:
  - DRAIN occupies cycles T+1..T+SIZE.
  - `done` is high during T+SIZE, coincident with the last element on `data_out[SIZE-1]`.
  - The feeder is back in IDLE, with `in_ready`=1, at T+SIZE+1.
- Throughput: one vector per cycle in STREAM. There is a SIZE-cycle gap between batches.
- `in_ready` and `busy` are combinational from the state register only. There is no combinational path from `in_valid` to `in_ready`.
- `done` is decoded from registered state and counter; it is not combinational from inputs.

## Structure
- Shared package `feeder_pkg` holds the `feeder_state_t` enum (IDLE, STREAM, DRAIN) and a `DRAIN_CNT_W(SIZE)` width function.
- Sub-module `skew_line #(DEPTH, DATA_WIDTH)`: a delay line of data plus valid with asynchronous active-high clear. The top level generates one per row with DEPTH=r+1.
- The FSM and drain counter live in the top level.

## Test plan
- SIZE=3, reset released, idle: all outputs 0 except `in_ready`=1. No `row_valid` bit ever rises.
- SIZE=3, back-to-back vectors {1,2,3}, {4,5,6}, {7,8,9} at cycles 0-2, last on the third:
  - `data_out[0]`=1,4,7 at cycles 1-3.
  - `data_out[1]`=2,5,8 at cycles 2-4.
  - `data_out[2]`=3,6,9 at cycles 3-5.
  - `done` at cycle 5, `in_ready` low during cycles 3-5.
- SIZE=3, bubble: {1,1,1} at cycle 0, none at cycle 1, {2,2,2}+last at cycle 2 → row 2 shows 1, 0 (`row_valid`=0), 2 at cycles 3, 4, 5.
- SIZE=3, `in_valid` held during DRAIN with {9,9,9} → not captured. It is accepted at the first IDLE cycle and appears on row 0 one cycle later.
- SIZE=3, `rst` pulsed at cycle 1 of a batch → all `data_out`/`row_valid` 0 immediately, no `done`, IDLE afterwards.
- SIZE=1, single vector {5}+last at cycle 0 → `data_out[0]`=5 and `done`=1 at cycle 1, IDLE at cycle 2.
